// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per RUN cycle, MSB first.
// A zero divisor finishes immediately with an all-ones quotient and the dividend as remainder.
module restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned SumW = WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [SumW-1:0]  trial_sum;
    logic             no_borrow;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    // Trial subtract in WIDTH+1 bits; the extra sum bit is the carry-out.
    always_comb begin
        r_shift   = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
        trial_sum = {1'b0, r_shift} + {1'b0, ~{1'b0, b_q}} + SumW'(1);
        no_borrow = trial_sum[SumW-1];
        r_step    = no_borrow ? trial_sum[WIDTH:0] : r_shift;
        q_step    = {q_q[WIDTH-2:0], no_borrow};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (b == '0) begin
                        quotient_d  = '1;
                        remainder_d = a;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        a_d     = a;
                        b_d     = b;
                        r_d     = '0;
                        q_d     = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                a_d   = a_q << 1;
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    quotient_d  = q_step;
                    remainder_d = r_step[WIDTH-1:0];
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider at WIDTH=4: stimulus pushes expected results,
// a negedge monitor pops and compares them (including completion cycle) on every done pulse.
module tb_restoring_divider;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        int q;
        int r;
        int dbz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a_i),
        .b          (b_i),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(quotient), e.q);
                check("remainder", int'(remainder), e.r);
                check("div_by_zero", int'(div_by_zero), e.dbz);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic exp_t model(input int a, input int b, input int accept_cyc);
        exp_t e;
        if (b == 0) begin
            e.q   = (1 << W) - 1;
            e.r   = a;
            e.dbz = 1;
            e.cyc = accept_cyc;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 0;
            e.cyc = accept_cyc + W;
        end
        return e;
    endfunction

    // Issue one operation from IDLE and wait (bounded) for its done pulse.
    task automatic do_op(input int a, input int b);
        int busy_n;
        bit got;
        @(negedge clk);
        start = 1'b1;
        a_i   = W'(a);
        b_i   = W'(b);
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start  = 1'b0;
        a_i    = W'($urandom);
        b_i    = W'($urandom);
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
        check("done_seen", int'(got), 1);
        check("busy_cycles", busy_n, (b == 0) ? 0 : int'(W));
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_div_by_zero", int'(div_by_zero), 0);
    endtask

    initial begin
        int c0;
        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        do_op(13, 3);
        do_op(15, 1);
        do_op(0, 7);
        do_op(9, 0);
        do_op(15, 15);
        do_op(1, 15);
        do_op(15, 2);

        // Start held high: one op per IDLE entry, second accepted two edges after the first done.
        @(negedge clk);
        start = 1'b1;
        a_i   = 4'd6;
        b_i   = 4'd9;
        c0    = cyc + 1;
        sb.push_back(model(6, 9, c0));
        sb.push_back(model(6, 9, c0 + int'(W) + 2));
        repeat (8) @(negedge clk);
        start = 1'b0;
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        repeat (20) @(negedge clk);
        check("held_start_pending", sb.size(), 0);

        do_op(15, 2);

        // Reset in the 2nd RUN cycle abandons the op; start alongside rst is ignored.
        @(negedge clk);
        start = 1'b1;
        a_i   = 4'd14;
        b_i   = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("run_busy", int'(busy), 1);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_reset_outputs();
        repeat (10) @(negedge clk);
        check("idle_after_rst", int'(busy), 0);
        do_op(14, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(a, b);
            end
        end

        repeat (4) @(negedge clk);
        check("final_pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion, expected bench to finish by 500000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand, quotient and remainder width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  unsigned dividend; sampled on the edge that accepts start.
REQ-006 SHALL have port b  input  WIDTH  unsigned divisor; sampled on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress (state RUN).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results are valid when it is high.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; set when the accepted divisor is 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 and b!=0 SHALL latch a and b, clear the partial remainder, clear the iteration count, clear div_by_zero, and go to RUN.
REQ-014 IDLE with start=1 and b==0 SHALL go directly to DONE. On that edge: quotient = all ones, remainder = a, div_by_zero = 1.
REQ-015 Each RUN cycle SHALL perform one restoring step, MSB first:
- shift the next dividend bit into the partial remainder R (width WIDTH+1);
- trial-subtract the divisor as R + ~{0,b} + 1 (two's-complement form, carry-in 1);
- carry-out = 1 means no borrow: keep the difference and shift quotient bit 1;
- carry-out = 0 means borrow: restore R and shift quotient bit 0.
REQ-016 RUN SHALL last exactly WIDTH cycles, then go to DONE. On the final RUN edge, quotient and remainder are loaded with the final values.
REQ-017 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-018 done SHALL be 0 in every state except DONE. busy SHALL be 1 only in RUN.
REQ-019 Latency, counted from the edge that accepts start:
- b!=0: done high during the cycle following edge WIDTH (edge WIDTH+1 samples done=1);
- b==0: done high during the cycle following edge 0.
REQ-020 start SHALL be ignored in RUN and DONE. Inputs a and b SHALL not affect an operation after acceptance.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next completed operation or reset.
REQ-022 Results SHALL satisfy a == quotient*b + remainder and remainder < b for all b!=0 and all a, including a=0 and a<b (quotient 0, remainder a).
REQ-023 The subtraction SHALL use WIDTH+1-bit arithmetic so that it never overflows for a or b equal to the maximum value.

Reset
REQ-024 With rst=1 on a rising edge, the FSM SHALL go to IDLE and busy, done, quotient, remainder and div_by_zero SHALL all be 0.
REQ-025 Reset SHALL take priority over start and over any state, including mid-RUN. An in-progress operation SHALL be abandoned with no done pulse.
REQ-026 start sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-027 a=13, b=3, start pulse from IDLE -> busy high for 4 cycles, then done=1 for 1 cycle; quotient=4, remainder=1, div_by_zero=0.
REQ-028 a=15, b=1, then a=0, b=7 -> first result quotient=15, remainder=0; second result quotient=0, remainder=0.
REQ-029 a=9, b=0 -> done high the cycle after acceptance, busy never high; quotient=15, remainder=9, div_by_zero=1.
REQ-030 a=6, b=9, start held high for 8 cycles -> exactly one operation per IDLE entry; results quotient=0, remainder=6; a second start accepted only after DONE.
REQ-031 a=14, b=5 started, then rst=1 on the 2nd RUN cycle -> no done pulse; all outputs 0; FSM in IDLE; next start with a=14, b=5 completes with quotient=2, remainder=4.
REQ-032 Exhaustive sweep of all 256 (a,b) pairs at WIDTH=4 -> every result matches a/b and a%b; b=0 cases are flagged per REQ-014.
